// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of a single data-memory controller port
// between NUM_REQ requesters. Only one transaction is outstanding at a time.
// The granted request is latched and held on the controller port until the
// controller accepts it. The arbiter then waits for completion and routes the
// completion pulse and read data back to the owning requester. Sticky watchdog
// and protocol-error flags are provided for debug.
module mem_req_arbiter #(
    parameter int NUM_REQ             = 2,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int D_MEMORY_ADDR_WIDTH = 32,
    parameter int REG_VAL_WIDTH       = 32,
    parameter int OP_W                = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*OP_W-1:0]                req_op,
    input  logic [NUM_REQ*D_MEMORY_ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*REG_VAL_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     resp_valid,
    output logic [REG_VAL_WIDTH-1:0]               resp_data,
    output logic                                   mc_req_valid,
    output logic [OP_W-1:0]                        mc_req_op,
    output logic [D_MEMORY_ADDR_WIDTH-1:0]         mc_req_address,
    output logic [REG_VAL_WIDTH-1:0]               mc_req_data,
    input  logic                                   mc_ready,
    input  logic                                   mc_done,
    input  logic [REG_VAL_WIDTH-1:0]               mc_data,
    output logic                                   busy,
    output logic                                   err_timeout,
    output logic                                   err_spurious
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [OP_W-1:0] NO_MEM_OP = '0;

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]                     r_state;
    logic [GW-1:0]                  r_rr_ptr;
    logic [GW-1:0]                  r_owner;
    logic [OP_W-1:0]                r_op;
    logic [D_MEMORY_ADDR_WIDTH-1:0] r_addr;
    logic [REG_VAL_WIDTH-1:0]       r_data;
    logic [CW-1:0]                  r_cnt;
    logic [NUM_REQ-1:0]             r_resp_valid;
    logic [REG_VAL_WIDTH-1:0]       r_resp_data;
    logic                           r_err_timeout;
    logic                           r_err_spurious;

    logic                           w_any;
    logic [GW-1:0]                  w_grant;
    logic [GW-1:0]                  w_idx;
    logic [NUM_REQ-1:0]             w_grant_oh;
    logic [NUM_REQ-1:0]             w_owner_oh;
    logic [GW-1:0]                  w_rr_next;
    logic                           w_to_hit;

    // Round-robin search: first valid requester starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant;
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_rr_next  = (r_owner == GW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    // Fires on the last wait cycle before the limit, so the flag rises as the count reaches it.
    assign w_to_hit   = (TIMEOUT_CYCLES > 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Request path: arbitrate, latch the granted request, hand it to the controller, wait for completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_op     <= NO_MEM_OP;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_op    <= req_op[int'(w_grant)*OP_W +: OP_W];
                        r_addr  <= req_address[int'(w_grant)*D_MEMORY_ADDR_WIDTH +: D_MEMORY_ADDR_WIDTH];
                        r_data  <= req_data[int'(w_grant)*REG_VAL_WIDTH +: REG_VAL_WIDTH];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mc_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mc_done) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Watchdog: count cycles spent waiting for completion and flag when the limit is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else if (r_state == ST_ISSUE && mc_ready) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT && !mc_done) begin
            if (r_cnt != CW'(TIMEOUT_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    // Completion routing: one-cycle pulse to the owner; read data held between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else if (r_state == ST_WAIT && mc_done) begin
            r_resp_valid <= w_owner_oh;
            r_resp_data  <= mc_data;
        end else begin
            r_resp_valid <= '0;
        end
    end

    // Protocol check: a completion with no accepted transaction outstanding is flagged and otherwise ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_spurious <= 1'b0;
        end else if (mc_done && r_state != ST_WAIT) begin
            r_err_spurious <= 1'b1;
        end
    end

    // Ready is gated with reset so every output reads zero while reset is asserted.
    assign req_ready      = (reset_n && r_state == ST_ARB && w_any) ? w_grant_oh : '0;
    assign mc_req_valid   = (r_state == ST_ISSUE);
    assign mc_req_op      = r_op;
    assign mc_req_address = r_addr;
    assign mc_req_data    = r_data;
    assign busy           = (r_state != ST_ARB);
    assign resp_valid     = r_resp_valid;
    assign resp_data      = r_resp_data;
    assign err_timeout    = r_err_timeout;
    assign err_spurious   = r_err_spurious;

endmodule
